spi_master_driver: RTL and testbench
====================================

Name: spi_master_driver

Overview:
Synchronous SPI frame generator that sits directly upstream of the team's SPI slave and drives its SS_n/MOSI inputs.
- Accepts 10-bit RAM commands (2-bit opcode + 8-bit payload) over a valid/ready interface.
- Serialises each command into the slave's frame format.
- For read-data commands, captures the 8-bit MISO reply and returns it on a response port.
- Used as the system-side front end and as the stimulus engine in the SPI+RAM integration bench.

Parameters:
RD_GAP, 4, cycles SS_n stays low between the last payload bit and the first MISO sample (covers slave rx_valid + RAM tx_valid latency)
IDLE_CYCLES, 2, minimum cycles SS_n is held high between frames

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high when IDLE and able to accept a command
cmd_op  in  2  opcode: 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
cmd_data  in  8  payload (address or write data; don't-care for 11)
rsp_valid  out  1  one-cycle pulse, read data available
rsp_data  out  8  byte captured from MISO; held until next rsp_valid
busy  out  1  high from command accept until end of IDLE_CYCLES gap
SS_n  out  1  slave select, active low
MOSI  out  1  serial data to slave
MISO  in  1  serial data from slave
err_seq  out  1  sequence-error pulse (only with SPI_MASTER_SEQ_CHK_EN; otherwise tied 0)

Behaviour:
- Reset (async, any state): SS_n=1, MOSI=0, cmd_ready=0 during reset then 1, rsp_valid=0, rsp_data=0, busy=0, err_seq=0. FSM->IDLE, counters=0.
- Handshake: a command is accepted on a cycle with cmd_valid & cmd_ready. {cmd_op,cmd_data} is latched into a 10-bit shift register. cmd_ready drops the next cycle.
- States: IDLE -> SEL -> CMD -> SHIFT -> (GAP -> RECV if op==11) -> DONE -> IDLE.
- IDLE: SS_n=1, MOSI=0. Accepting a command moves to SEL.
- SEL (1 cycle): SS_n=0, MOSI=0. This is the dead cycle while the slave leaves its idle state.
- CMD (1 cycle): MOSI=cmd_op[1] (read/write select bit).
- SHIFT (10 cycles): MOSI = shift reg MSB first, i.e. op[1], op[0], data[7]..data[0]. A 4-bit counter runs 0..9.
- After SHIFT:
  - ops 00/01/10 go to DONE.
  - op 11 goes to GAP.
- GAP (RD_GAP cycles): SS_n=0, MOSI=0.
- RECV (8 cycles): sample MISO each rising edge, MSB first, into rsp shift reg.
- DONE: SS_n=1 for IDLE_CYCLES cycles, MOSI=0.
  - On DONE entry after RECV: rsp_data updates and rsp_valid pulses for exactly 1 cycle.
  - Then IDLE; cmd_ready=1 on the first IDLE cycle.
- Frame lengths with SS_n low:
  - 12 cycles for ops 00/01/10.
  - 12+RD_GAP+8 cycles for op 11.
- Command-to-next-accept latency = SS_n-low length + IDLE_CYCLES + 1.
- cmd_valid while busy: ignored and not queued. The requester must hold it until cmd_ready.
- MISO is not sampled outside RECV.
- rsp_data is unchanged by non-read frames.
- Counters saturate at their terminal value and never wrap mid-frame.

Optional Feature:
SPI_MASTER_SEQ_CHK_EN:
- Defined:
  - A flag is set when an op 10 frame completes and cleared when an op 11 frame completes.
  - An op 11 command with the flag clear is still accepted (one cmd_ready handshake) but produces no frame: SS_n stays 1, err_seq pulses 1 cycle, and the FSM returns to IDLE.
  - The flag clears on reset.
- Undefined: no flag, err_seq tied 0, every command produces a frame.

Test Plan:
- Reset: rst_n low mid-SHIFT (cycle 5) -> SS_n=1, MOSI=0, rsp_valid=0 immediately (asynchronous). cmd_ready=1 the first cycle after release.
- Write addr: op=00, data=8'hA5 -> SS_n low 12 cycles; MOSI sequence 0,0,0,0,1,0,1,0,0,1,0,1; connected slave shows rx_data=10'h0A5, rx_valid=1.
- Write data: op=01, data=8'h3C -> slave rx_data=10'h13C. No rsp_valid.
- Read: op=10, data=8'h0F then op=11 with slave/RAM returning 8'h5A -> op 11 SS_n-low window 24 cycles with RD_GAP=4; rsp_valid single pulse; rsp_data=8'h5A.
- Back-to-back: cmd_valid held high with 3 commands -> each accepted only when cmd_ready=1; SS_n high ≥IDLE_CYCLES=2 between frames; no command lost or duplicated.
- SPI_MASTER_SEQ_CHK_EN: op 11 issued after reset without prior op 10 -> err_seq one-cycle pulse, SS_n never drops. Then op 10 followed by op 11 -> normal frame, err_seq=0.

Source files
------------

// File: rtl/spi_master_driver.sv
// SPI frame generator feeding the SPI slave: serialises 10-bit RAM commands and captures read replies.
// Optional sequence checking (op 11 requires a completed op 10 first) is enabled by SPI_MASTER_SEQ_CHK_EN.
module spi_master_driver #(
    parameter int RD_GAP      = 4,
    parameter int IDLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO,
    output logic       err_seq
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_CMD,
        S_SHIFT,
        S_GAP,
        S_RECV,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0] SHIFT_LAST = 8'd9;
    localparam logic [7:0] GAP_LAST   = 8'(RD_GAP - 1);
    localparam logic [7:0] RECV_LAST  = 8'd7;
    localparam logic [7:0] DONE_LAST  = 8'(IDLE_CYCLES - 1);

    state_t     state;
    state_t     state_nx;
    logic [7:0] cnt;
    logic [7:0] cnt_last;
    logic [9:0] sh;
    logic [1:0] op;
    logic [7:0] rsp_sh;
    logic [7:0] rsp_q;
    logic       rsp_vld_q;
    logic       rdy_en;
    logic       accept;
    logic       seq_bad;

    // cmd_ready stays low while reset is held and rises on the first edge after release
    assign cmd_ready = rdy_en && (state == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;

`ifdef SPI_MASTER_SEQ_CHK_EN
    logic seq_flag;
    assign seq_bad = (cmd_op == 2'b11) && !seq_flag;
    assign err_seq = (state == S_ERR);
`else
    assign seq_bad = 1'b0;
    assign err_seq = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_last = 8'd0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = seq_bad ? S_ERR : S_SEL;
                end
            end
            S_SEL:   state_nx = S_CMD;
            S_CMD:   state_nx = S_SHIFT;
            S_SHIFT: begin
                cnt_last = SHIFT_LAST;
                if (cnt == SHIFT_LAST) begin
                    state_nx = (op == 2'b11) ? S_GAP : S_DONE;
                end
            end
            S_GAP: begin
                cnt_last = GAP_LAST;
                if (cnt == GAP_LAST) begin
                    state_nx = S_RECV;
                end
            end
            S_RECV: begin
                cnt_last = RECV_LAST;
                if (cnt == RECV_LAST) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                cnt_last = DONE_LAST;
                if (cnt == DONE_LAST) begin
                    state_nx = S_IDLE;
                end
            end
            S_ERR:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // One shared counter: cleared on every state change, saturating at the state's last index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 8'd0;
            sh        <= 10'd0;
            op        <= 2'b00;
            rsp_sh    <= 8'd0;
            rsp_q     <= 8'd0;
            rsp_vld_q <= 1'b0;
            rdy_en    <= 1'b0;
        end else begin
            rdy_en    <= 1'b1;
            rsp_vld_q <= 1'b0;
            if (state_nx != state) begin
                cnt <= 8'd0;
            end else if (cnt != cnt_last) begin
                cnt <= cnt + 8'd1;
            end
            if (accept) begin
                sh <= {cmd_op, cmd_data};
                op <= cmd_op;
            end else if (state == S_SHIFT) begin
                sh <= {sh[8:0], 1'b0};
            end
            // The final MISO bit is folded straight into rsp_q on the edge that enters DONE
            if (state == S_RECV) begin
                rsp_sh <= {rsp_sh[6:0], MISO};
                if (cnt == RECV_LAST) begin
                    rsp_q     <= {rsp_sh[6:0], MISO};
                    rsp_vld_q <= 1'b1;
                end
            end
        end
    end

`ifdef SPI_MASTER_SEQ_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_flag <= 1'b0;
        end else if (state == S_SHIFT && state_nx == S_DONE && op == 2'b10) begin
            seq_flag <= 1'b1;
        end else if (state == S_RECV && state_nx == S_DONE) begin
            seq_flag <= 1'b0;
        end
    end
`endif

    assign SS_n      = !(state inside {S_SEL, S_CMD, S_SHIFT, S_GAP, S_RECV});
    assign MOSI      = (state == S_CMD || state == S_SHIFT) ? sh[9] : 1'b0;
    assign busy      = (state != S_IDLE);
    assign rsp_valid = rsp_vld_q;
    assign rsp_data  = rsp_q;

endmodule

// File: tb/tb_spi_master_driver.sv
// Self-checking bench for spi_master_driver: a slave-side monitor records each SS_n-low window
// and drives MISO replies; expectations come from the frame-format rules applied per command.
module tb_spi_master_driver;
    localparam int RD_GAP      = 4;
    localparam int IDLE_CYCLES = 2;
    localparam int LEN_SHORT   = 12;
    localparam int LEN_READ    = 12 + RD_GAP + 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic       err_seq;

    spi_master_driver #(.RD_GAP(RD_GAP), .IDLE_CYCLES(IDLE_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO), .err_seq(err_seq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] miso_reply = 8'h00;
    logic       model_flag = 1'b0;
    logic [7:0] model_rsp  = 8'h00;
    bit         seq_chk    = 1'b0;

    int         f_len[$];
    int         f_bits[$];
    int         f_extra[$];
    int         rsp_cnt  = 0;
    int         rsp_wide = 0;
    int         err_cnt  = 0;
    int         err_wide = 0;
    int         busy_bad = 0;
    int         min_gap  = 1000;
    logic [7:0] rsp_seen = 8'h00;

    // Slave-side observer: records frames and drives the reply bits only in the RECV window
    task automatic slave_monitor();
        int         low_cnt = 0;
        int         hi_cnt  = 0;
        int         extra   = 0;
        int         rsp_run = 0;
        int         err_run = 0;
        bit         in_frame = 1'b0;
        bit         seen     = 1'b0;
        logic [11:0] bits    = 12'd0;
        MISO = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 1'b0; seen = 1'b0; low_cnt = 0; hi_cnt = 0;
                rsp_run = 0; err_run = 0; MISO = 1'b0;
            end else begin
                if (SS_n === 1'b0) begin
                    if (!in_frame) begin
                        in_frame = 1'b1; low_cnt = 0; bits = 12'd0; extra = 0;
                        if (seen && hi_cnt < min_gap) min_gap = hi_cnt;
                    end
                    if (busy !== 1'b1) busy_bad++;
                    if (low_cnt < 12) bits = {bits[10:0], MOSI};
                    else if (MOSI !== 1'b0) extra++;
                    if (low_cnt >= 16 && low_cnt <= 23) MISO = miso_reply[23 - low_cnt];
                    else MISO = 1'($urandom);
                    low_cnt++;
                end else begin
                    if (in_frame) begin
                        f_len.push_back(low_cnt);
                        f_bits.push_back(int'(bits));
                        f_extra.push_back(extra);
                        in_frame = 1'b0; seen = 1'b1; hi_cnt = 0;
                    end
                    hi_cnt++;
                    MISO = 1'($urandom);
                end
                if (rsp_valid === 1'b1) begin
                    rsp_run++;
                    if (rsp_run == 1) begin rsp_cnt++; rsp_seen = rsp_data; end
                    else rsp_wide++;
                end else rsp_run = 0;
                if (err_seq === 1'b1) begin
                    err_run++;
                    if (err_run == 1) err_cnt++;
                    else err_wide++;
                end else err_run = 0;
            end
        end
    endtask

    initial slave_monitor();

    function automatic int exp_bits(input logic [1:0] op, input logic [7:0] data);
        logic [11:0] w;
        w = {1'b0, op[1], op, data};
        return int'(w);
    endfunction

    task automatic do_cmd(input string name, input logic [1:0] op, input logic [7:0] data,
                          input logic [7:0] reply);
        int n;
        int n0, r0, e0, wide0;
        bit expect_err;
        miso_reply = reply;
        n0 = f_len.size(); r0 = rsp_cnt; e0 = err_cnt; wide0 = rsp_wide + err_wide;
        expect_err = seq_chk && (op == 2'b11) && !model_flag;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL %s accept: cmd_ready=%b required 1", name, cmd_ready);
            cmd_valid = 1'b0; return;
        end
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        #2;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL %s done: cmd_ready=%b busy=%b required 1/0", name, cmd_ready, busy);
        end
        checks++;
        if (rsp_wide + err_wide !== wide0) begin
            errors++; $display("FAIL %s pulse_width: wide=%0d required %0d", name, rsp_wide + err_wide, wide0);
        end
        if (expect_err) begin
            checks++;
            if (f_len.size() !== n0 || err_cnt !== e0 + 1) begin
                errors++; $display("FAIL %s seq_err: frames=%0d errs=%0d required %0d/%0d",
                                   name, f_len.size(), err_cnt, n0, e0 + 1);
            end
        end else begin
            checks++;
            if (f_len.size() !== n0 + 1 || err_cnt !== e0) begin
                errors++; $display("FAIL %s frame_count: frames=%0d errs=%0d required %0d/%0d",
                                   name, f_len.size(), err_cnt, n0 + 1, e0);
            end else begin
                checks++;
                if (f_len[n0] !== ((op == 2'b11) ? LEN_READ : LEN_SHORT)) begin
                    errors++; $display("FAIL %s ss_len: got %0d required %0d", name, f_len[n0],
                                       (op == 2'b11) ? LEN_READ : LEN_SHORT);
                end
                checks++;
                if (f_bits[n0] !== exp_bits(op, data) || f_extra[n0] !== 0) begin
                    errors++; $display("FAIL %s mosi: got %03h extra=%0d required %03h extra=0",
                                       name, f_bits[n0], f_extra[n0], exp_bits(op, data));
                end
            end
            if (op == 2'b11) begin
                model_rsp = reply;
                checks++;
                if (rsp_cnt !== r0 + 1 || rsp_seen !== reply) begin
                    errors++; $display("FAIL %s rsp: pulses=%0d data=%02h required %0d/%02h",
                                       name, rsp_cnt - r0, rsp_seen, 1, reply);
                end
            end else begin
                checks++;
                if (rsp_cnt !== r0) begin
                    errors++; $display("FAIL %s no_rsp: pulses=%0d required 0", name, rsp_cnt - r0);
                end
            end
            checks++;
            if (rsp_data !== model_rsp) begin
                errors++; $display("FAIL %s rsp_hold: rsp_data=%02h required %02h", name, rsp_data, model_rsp);
            end
            if (op == 2'b10) model_flag = 1'b1;
            if (op == 2'b11) model_flag = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00;
        #12;
        checks++;
        if (SS_n !== 1'b1 || MOSI !== 1'b0 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0 ||
            rsp_data !== 8'h00 || busy !== 1'b0 || err_seq !== 1'b0) begin
            errors++; $display("FAIL reset_values: SS_n=%b MOSI=%b rdy=%b rv=%b rd=%02h busy=%b err=%b",
                               SS_n, MOSI, cmd_ready, rsp_valid, rsp_data, busy, err_seq);
        end
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || SS_n !== 1'b1) begin
            errors++; $display("FAIL reset_release: cmd_ready=%b busy=%b SS_n=%b required 1/0/1",
                               cmd_ready, busy, SS_n);
        end
    endtask

    task automatic test_midframe_reset();
        int n;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 8'hA5;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        @(posedge clk); #1 cmd_valid = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (SS_n !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL midframe_active: SS_n=%b busy=%b required 0/1", SS_n, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (SS_n !== 1'b1 || MOSI !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0 ||
            rsp_data !== 8'h00 || busy !== 1'b0) begin
            errors++; $display("FAIL async_reset: SS_n=%b MOSI=%b rv=%b rdy=%b rd=%02h busy=%b",
                               SS_n, MOSI, rsp_valid, cmd_ready, rsp_data, busy);
        end
        model_flag = 1'b0; model_rsp = 8'h00;
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || SS_n !== 1'b1) begin
            errors++; $display("FAIL reset_recover: cmd_ready=%b SS_n=%b required 1/1", cmd_ready, SS_n);
        end
    endtask

    task automatic test_write_read();
        do_cmd("wr_addr", 2'b00, 8'hA5, 8'h00);
        do_cmd("wr_data", 2'b01, 8'h3C, 8'h00);
        do_cmd("rd_addr", 2'b10, 8'h0F, 8'h00);
        do_cmd("rd_data", 2'b11, 8'h00, 8'h5A);
        do_cmd("wr_after_rd", 2'b01, 8'hC3, 8'hFF);
    endtask

    task automatic test_seq_check();
        do_cmd("seq_orphan_rd", 2'b11, 8'h00, 8'h81);
        do_cmd("seq_rd_addr", 2'b10, 8'h22, 8'h00);
        do_cmd("seq_rd_data", 2'b11, 8'h00, 8'h7E);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            do_cmd("random", 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] ops[3];
        logic [7:0] dat[3];
        time        t_acc[3];
        int         n, n0, r0;
        bit         ok;
        ops[0] = 2'b10; ops[1] = 2'b11; ops[2] = 2'b01;
        for (int i = 0; i < 3; i++) dat[i] = 8'($urandom);
        miso_reply = 8'($urandom);
        n0 = f_len.size(); r0 = rsp_cnt; min_gap = 1000; ok = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_op = ops[i]; cmd_data = dat[i];
            n = 0;
            while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
            if (cmd_ready !== 1'b1) begin ok = 1'b0; break; end
            @(posedge clk); t_acc[i] = $time;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        repeat (40) @(negedge clk);
        #2;
        checks++;
        if (!ok || f_len.size() !== n0 + 3) begin
            errors++; $display("FAIL b2b_count: accepted_ok=%0d frames=%0d required 1/%0d", ok, f_len.size() - n0, 3);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (f_bits[n0 + i] !== exp_bits(ops[i], dat[i]) ||
                    f_len[n0 + i] !== ((ops[i] == 2'b11) ? LEN_READ : LEN_SHORT)) begin
                    errors++; $display("FAIL b2b_frame%0d: bits=%03h len=%0d required %03h", i,
                                       f_bits[n0 + i], f_len[n0 + i], exp_bits(ops[i], dat[i]));
                end
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (t_acc[i + 1] - t_acc[i] !=
                    10 * (((ops[i] == 2'b11) ? LEN_READ : LEN_SHORT) + IDLE_CYCLES + 1)) begin
                    errors++; $display("FAIL b2b_latency%0d: got %0t required %0d", i, t_acc[i + 1] - t_acc[i],
                                       10 * (((ops[i] == 2'b11) ? LEN_READ : LEN_SHORT) + IDLE_CYCLES + 1));
                end
            end
            checks++;
            if (min_gap < IDLE_CYCLES || rsp_cnt !== r0 + 1 || rsp_seen !== miso_reply) begin
                errors++; $display("FAIL b2b_gap_rsp: min_gap=%0d pulses=%0d data=%02h required >=%0d/1/%02h",
                                   min_gap, rsp_cnt - r0, rsp_seen, IDLE_CYCLES, miso_reply);
            end
            model_flag = 1'b0; model_rsp = miso_reply;
        end
    endtask

    initial begin
`ifdef SPI_MASTER_SEQ_CHK_EN
        seq_chk = 1'b1;
`endif
        test_reset();
        if (seq_chk) test_seq_check();
        test_write_read();
        test_midframe_reset();
        if (seq_chk) test_seq_check();
        test_random();
        test_back_to_back();
        checks++;
        if (busy_bad !== 0) begin
            errors++; $display("FAIL busy_during_frame: bad_cycles=%0d required 0", busy_bad);
        end
        if (!seq_chk) begin
            checks++;
            if (err_cnt !== 0) begin
                errors++; $display("FAIL err_seq_tied: pulses=%0d required 0", err_cnt);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
